// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer.
// FSM state encoding used by shift_seq_ctrl.
package shift_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_counter.sv
// Loadable shift-step down-counter.
// Clamps the requested count to MAX_COUNT and flags zero/one.
module shift_seq_ctrl_counter #(
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 7,
    parameter int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_dec,
    output logic [CW-1:0]    o_cnt,
    output logic             o_cnt_zero,
    output logic             o_cnt_one
);

    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_COUNT);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_clamped;

    assign w_clamped = (i_count > MAXC) ? CW'(MAX_COUNT) : CW'(i_count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_clamped;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_zero = (r_cnt == '0);
    assign o_cnt_one  = (r_cnt == CW'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external parallel-load shift register.
// Loads a value, lets it shift N clocks, then freezes and returns it.
module shift_seq_ctrl
    import shift_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] sr_po,
    output logic             sr_load,
    output logic [WIDTH-1:0] sr_load_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_data_q;
    logic             w_accept;
    logic             w_dec;
    logic             w_cnt_zero;
    logic             w_cnt_one;
    logic [CW-1:0]    w_cnt;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_dec    = (r_state == ST_SHIFT);

    shift_seq_ctrl_counter #(
        .CNT_W     (CNT_W),
        .MAX_COUNT (MAX_COUNT),
        .CW        (CW)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_count    (cmd_count),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_cnt_zero (w_cnt_zero),
        .o_cnt_one  (w_cnt_one)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_data_q <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_data_q <= cmd_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (cmd_valid) w_next = ST_LOAD;
            ST_LOAD:  w_next = w_cnt_zero ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (w_cnt_one) w_next = ST_DONE;
            ST_DONE:  if (res_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // IDLE and DONE reload the register with its own output to freeze it.
    always_comb begin
        cmd_ready     = 1'b0;
        sr_load       = 1'b1;
        sr_load_value = sr_po;
        res_valid     = 1'b0;
        busy          = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: begin
                sr_load_value = r_data_q;
            end
            ST_SHIFT: begin
                sr_load       = 1'b0;
                sr_load_value = r_data_q;
            end
            ST_DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign res_data = sr_po;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed and random checks of shift_seq_ctrl driving a left-shift-by-1 register.
// The shift register itself is modelled here as the surrounding parent.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = '0;
    logic [3:0] cmd_count = '0;
    logic [7:0] sr_po;
    logic       sr_load;
    logic [7:0] sr_load_value;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(
        .WIDTH     (8),
        .CNT_W     (4),
        .MAX_COUNT (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .cmd_count     (cmd_count),
        .sr_po         (sr_po),
        .sr_load       (sr_load),
        .sr_load_value (sr_load_value),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .busy          (busy)
    );

    // shift_reg: LEFT, SHIFT_AMOUNT=1, shares rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_po <= '0;
        else if (sr_load) sr_po <= sr_load_value;
        else sr_po <= {sr_po[6:0], 1'b0};
    end

    task automatic send_cmd(input logic [7:0] d, input logic [3:0] c,
                            output int lat, output bit busy_ok);
        busy_ok   = 1'b1;
        lat       = -1;
        cmd_data  = d;
        cmd_count = c;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            if (res_valid) begin
                lat = i;
                break;
            end
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || sr_load !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b load=%b rv=%b busy=%b, want 1 1 0 0",
                     cmd_ready, sr_load, res_valid, busy);
        end
        n_checks++;
        if (sr_load_value !== sr_po) begin
            n_fail++;
            $display("FAIL reset_load_value: got %h want %h", sr_load_value, sr_po);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        bit bok;
        res_ready = 1'b1;
        send_cmd(8'h09, 4'd3, lat, bok);
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want 4", lat);
        end
        n_checks++;
        if (res_data !== 8'h48) begin
            n_fail++;
            $display("FAIL basic_data: got %h want 48", res_data);
        end
        n_checks++;
        if (!bok) begin
            n_fail++;
            $display("FAIL basic_busy: got low during command want high");
        end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_return_idle: busy=%b rdy=%b rv=%b want 0 1 0",
                     busy, cmd_ready, res_valid);
        end
    endtask

    task automatic test_zero_count();
        int lat;
        bit bok;
        send_cmd(8'hA5, 4'd0, lat, bok);
        n_checks++;
        if (lat !== 1 || res_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL zero_count: lat=%0d data=%h want 1 a5", lat, res_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        int lat;
        bit bok;
        send_cmd(8'h01, 4'd12, lat, bok);
        n_checks++;
        if (lat !== 8 || res_data !== 8'h80) begin
            n_fail++;
            $display("FAIL clamp: lat=%0d data=%h want 8 80", lat, res_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int lat;
        bit bok;
        res_ready = 1'b0;
        send_cmd(8'h09, 4'd3, lat, bok);
        n_checks++;
        if (lat !== 4 || res_data !== 8'h48) begin
            n_fail++;
            $display("FAIL stall_result: lat=%0d data=%h want 4 48", lat, res_data);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== 8'h48 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc %0d: rv=%b data=%h rdy=%b want 1 48 0",
                         i, res_valid, res_data, cmd_ready);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: busy=%b rdy=%b rv=%b want 0 1 0",
                     busy, cmd_ready, res_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        bit bok;
        res_ready = 1'b1;
        cmd_data  = 8'h09;
        cmd_count = 4'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1
            || sr_po !== 8'h00 || sr_load !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_shift: busy=%b rv=%b rdy=%b po=%h load=%b want 0 0 1 00 1",
                     busy, res_valid, cmd_ready, sr_po, sr_load);
        end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        send_cmd(8'h09, 4'd3, lat, bok);
        n_checks++;
        if (lat !== 4 || res_data !== 8'h48) begin
            n_fail++;
            $display("FAIL after_reset_cmd: lat=%0d data=%h want 4 48", lat, res_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        bit bok;
        logic [7:0] d;
        logic [3:0] c;
        int n;
        logic [7:0] exp;
        logic [7:0] hold;
        res_ready = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            d   = 8'($urandom);
            c   = 4'($urandom_range(0, 15));
            n   = (c > 4'd7) ? 7 : int'(c);
            exp = 8'(d << n);
            hold = sr_po;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                n_checks++;
                if (sr_po !== hold || cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_idle_hold #%0d: po=%h rdy=%b want %h 1",
                             k, sr_po, cmd_ready, hold);
                end
            end
            send_cmd(d, c, lat, bok);
            n_checks++;
            if (lat !== n + 1 || res_data !== exp || !bok) begin
                n_fail++;
                $display("FAIL rand_result #%0d d=%h c=%0d: lat=%0d data=%h busy_ok=%b want %0d %h 1",
                         k, d, c, lat, res_data, bok, n + 1, exp);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                n_checks++;
                if (res_valid !== 1'b1 || res_data !== exp) begin
                    n_fail++;
                    $display("FAIL rand_done_hold #%0d: rv=%b data=%h want 1 %h",
                             k, res_valid, res_data, exp);
                end
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            n_checks++;
            if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || sr_po !== exp) begin
                n_fail++;
                $display("FAIL rand_release #%0d: rv=%b rdy=%b po=%h want 0 1 %h",
                         k, res_valid, cmd_ready, sr_po, exp);
            end
        end
        res_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_clamp();
        test_stall();
        test_reset_mid_shift();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
